// File: rtl/arm7_pkg.sv
// Shared types for the arm7 decode stage.
//   uop_class_e : micro-op class as seen by execute (DP, MUL, MEM, BRANCH, SWI, UND)
//   COND_*      : ARM condition-field encodings
//   uop_t       : every field of the issued micro-op, registered as one unit
package arm7_pkg;

    typedef enum logic [2:0] {
        CLS_DP     = 3'd0,
        CLS_MUL    = 3'd1,
        CLS_MEM    = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_SWI    = 3'd4,
        CLS_UND    = 3'd5
    } uop_class_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef struct packed {
        uop_class_e  cls;
        logic [3:0]  opcode;
        logic        s;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [3:0]  rs;
        logic        imm_valid;
        logic [31:0] imm32;
        logic [1:0]  shift_type;
        logic [4:0]  shift_amt;
        logic        shift_reg;
        logic [3:0]  pubw;
        logic        link;
        logic        acc;
    } uop_t;

    localparam uop_t UOP_RESET = '0;

endpackage

// File: rtl/decode_if.sv
// Decode -> execute micro-op channel.
//   exec_valid / exec_ready : issue handshake (transfer when both high)
//   exec_done               : one-cycle retire pulse from execute
//   uop_*                   : micro-op fields, stable while exec_valid is high
// master = decode side, slave = execute side.
interface decode_if;
    logic        exec_valid;
    logic        exec_ready;
    logic        exec_done;
    logic [2:0]  uop_class;
    logic [3:0]  uop_opcode;
    logic        uop_s;
    logic [3:0]  uop_rd;
    logic [3:0]  uop_rn;
    logic [3:0]  uop_rm;
    logic [3:0]  uop_rs;
    logic        uop_imm_valid;
    logic [31:0] uop_imm32;
    logic [1:0]  uop_shift_type;
    logic [4:0]  uop_shift_amt;
    logic        uop_shift_reg;
    logic [3:0]  uop_pubw;
    logic        uop_link;
    logic        uop_acc;

    modport master (
        output exec_valid, uop_class, uop_opcode, uop_s, uop_rd, uop_rn, uop_rm, uop_rs,
               uop_imm_valid, uop_imm32, uop_shift_type, uop_shift_amt, uop_shift_reg,
               uop_pubw, uop_link, uop_acc,
        input  exec_ready, exec_done
    );

    modport slave (
        input  exec_valid, uop_class, uop_opcode, uop_s, uop_rd, uop_rn, uop_rm, uop_rs,
               uop_imm_valid, uop_imm32, uop_shift_type, uop_shift_amt, uop_shift_reg,
               uop_pubw, uop_link, uop_acc,
        output exec_ready, exec_done
    );
endinterface

// File: rtl/decode_cond_eval.sv
// ARM condition-code evaluator (purely combinational).
//   cond  : instruction bits [31:28]
//   flags : {N, Z, C, V}
//   pass  : 1 when the instruction should execute; NV never passes
module cond_eval
    import arm7_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);
    logic n, z, c, v;
    assign {n, z, c, v} = flags;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/decode.sv
// arm7 decode stage.
// Captures an instruction on the rising edge of decode_en, checks its
// condition against the CPSR flags, classifies it and expands immediates,
// then issues one micro-op over the exec handshake and stays busy until
// execute pulses exec_done.
//   clk, rst    : core clock, asynchronous active-high reset
//   decode_en   : from fetch, high while instr is valid
//   instr       : instruction word
//   cpsr_flags  : {N,Z,C,V}, sampled in the DECODE cycle
//   all_busy    : to fetch, high from capture until retirement
//   exec        : micro-op channel to execute (master side)
module decode
    import arm7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        decode_en,
    input  logic [31:0] instr,
    input  logic [3:0]  cpsr_flags,
    output logic        all_busy,
    decode_if.master    exec
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ISSUE  = 2'd2,
        S_WAIT   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        decode_en_q, decode_en_d;
    logic [31:0] instr_q, instr_d;
    uop_t        uop_q, uop_d;

    uop_t        uop_dec;
    uop_class_e  cls_dec;
    logic        cond_pass;
    logic        en_rise;
    logic [31:0] imm8_ext;
    logic [4:0]  rot_amt;
    logic [31:0] rot_imm;
    logic [31:0] br_imm;

    // A held decode_en must not re-trigger, so only the 0->1 transition counts.
    assign en_rise     = decode_en & ~decode_en_q;
    assign decode_en_d = decode_en;

    cond_eval u_cond_eval (
        .cond  (instr_q[31:28]),
        .flags (cpsr_flags),
        .pass  (cond_pass)
    );

    // Classification, highest priority first.
    always_comb begin
        cls_dec = CLS_UND;
        if (instr_q[27:24] == 4'b1111) begin
            cls_dec = CLS_SWI;
        end else if (instr_q[27:25] == 3'b101) begin
            cls_dec = CLS_BRANCH;
        end else if (instr_q[27:22] == 6'b000000 && instr_q[7:4] == 4'b1001) begin
            cls_dec = CLS_MUL;
        end else if (instr_q[27:26] == 2'b01) begin
            // Register-offset encoding with bit 4 set is the undefined space.
            cls_dec = (instr_q[25] && instr_q[4]) ? CLS_UND : CLS_MEM;
        end else if (instr_q[27:26] == 2'b00) begin
            cls_dec = CLS_DP;
        end
    end

    // Rotate-right of imm8 by 2*rot. A shift by 32 yields 0, so rot=0 leaves
    // the value untouched without a special case.
    assign imm8_ext = {24'd0, instr_q[7:0]};
    assign rot_amt  = {instr_q[11:8], 1'b0};
    assign rot_imm  = (imm8_ext >> rot_amt) | (imm8_ext << (6'd32 - {1'b0, rot_amt}));
    assign br_imm   = {{6{instr_q[23]}}, instr_q[23:0], 2'b00};

    always_comb begin
        uop_dec     = UOP_RESET;
        uop_dec.cls = cls_dec;
        case (cls_dec)
            CLS_DP: begin
                uop_dec.opcode = instr_q[24:21];
                uop_dec.s      = instr_q[20];
                uop_dec.rn     = instr_q[19:16];
                uop_dec.rd     = instr_q[15:12];
                if (instr_q[25]) begin
                    uop_dec.imm_valid = 1'b1;
                    uop_dec.imm32     = rot_imm;
                end else begin
                    uop_dec.rm         = instr_q[3:0];
                    uop_dec.rs         = instr_q[11:8];
                    uop_dec.shift_type = instr_q[6:5];
                    uop_dec.shift_amt  = instr_q[11:7];
                    uop_dec.shift_reg  = instr_q[4];
                end
            end
            CLS_MUL: begin
                // Multiply swaps the Rd/Rn field positions relative to DP.
                uop_dec.s   = instr_q[20];
                uop_dec.acc = instr_q[21];
                uop_dec.rd  = instr_q[19:16];
                uop_dec.rn  = instr_q[15:12];
                uop_dec.rs  = instr_q[11:8];
                uop_dec.rm  = instr_q[3:0];
            end
            CLS_MEM: begin
                uop_dec.s    = instr_q[20];
                uop_dec.rn   = instr_q[19:16];
                uop_dec.rd   = instr_q[15:12];
                uop_dec.pubw = instr_q[24:21];
                // For loads/stores I=0 means immediate offset (inverse of DP).
                if (!instr_q[25]) begin
                    uop_dec.imm_valid = 1'b1;
                    uop_dec.imm32     = {20'd0, instr_q[11:0]};
                end else begin
                    uop_dec.rm         = instr_q[3:0];
                    uop_dec.shift_type = instr_q[6:5];
                    uop_dec.shift_amt  = instr_q[11:7];
                end
            end
            CLS_BRANCH: begin
                uop_dec.link      = instr_q[24];
                uop_dec.imm_valid = 1'b1;
                uop_dec.imm32     = br_imm;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        uop_d   = uop_q;
        case (state_q)
            S_IDLE: begin
                if (en_rise) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cond_pass) begin
                    uop_d   = uop_dec;
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (exec.exec_ready) begin
                    state_d = exec.exec_done ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (exec.exec_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            decode_en_q <= 1'b0;
            instr_q     <= '0;
            uop_q       <= UOP_RESET;
        end else begin
            state_q     <= state_d;
            decode_en_q <= decode_en_d;
            instr_q     <= instr_d;
            uop_q       <= uop_d;
        end
    end

    // Busy is raised combinationally on the capture edge so fetch sees it in
    // the very first cycle; reset forces it low without waiting for a clock.
    assign all_busy = ((state_q != S_IDLE) | en_rise) & ~rst;

    assign exec.exec_valid     = (state_q == S_ISSUE);
    assign exec.uop_class      = uop_q.cls;
    assign exec.uop_opcode     = uop_q.opcode;
    assign exec.uop_s          = uop_q.s;
    assign exec.uop_rd         = uop_q.rd;
    assign exec.uop_rn         = uop_q.rn;
    assign exec.uop_rm         = uop_q.rm;
    assign exec.uop_rs         = uop_q.rs;
    assign exec.uop_imm_valid  = uop_q.imm_valid;
    assign exec.uop_imm32      = uop_q.imm32;
    assign exec.uop_shift_type = uop_q.shift_type;
    assign exec.uop_shift_amt  = uop_q.shift_amt;
    assign exec.uop_shift_reg  = uop_q.shift_reg;
    assign exec.uop_pubw       = uop_q.pubw;
    assign exec.uop_link       = uop_q.link;
    assign exec.uop_acc        = uop_q.acc;
endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the arm7 decode stage: directed cases followed by
// randomized instructions, each compared against a behavioural model.
module tb_decode;
    logic        clk = 1'b0;
    logic        rst;
    logic        decode_en;
    logic [31:0] instr;
    logic [3:0]  cpsr_flags;
    logic        all_busy;

    decode_if bus ();

    decode dut (
        .clk        (clk),
        .rst        (rst),
        .decode_en  (decode_en),
        .instr      (instr),
        .cpsr_flags (cpsr_flags),
        .all_busy   (all_busy),
        .exec       (bus)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;

    always @(posedge clk) begin
        if (!rst && bus.exec_valid && bus.exec_ready) accepts++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] iw;
        bit          pass;
        int          cls;
        bit          imm_valid;
        logic [31:0] imm32;
    } exp_t;

    function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] iw, input logic [3:0] f);
        exp_t        e;
        logic [31:0] val;
        int          off;
        e.iw        = iw;
        e.pass      = cond_ok(iw[31:28], f);
        e.imm_valid = 1'b0;
        e.imm32     = '0;
        if (iw[27:24] == 4'hF)                              e.cls = 4;
        else if (iw[27:25] == 3'b101)                       e.cls = 3;
        else if (iw[27:22] == 6'd0 && iw[7:4] == 4'b1001)   e.cls = 1;
        else if (iw[27:26] == 2'b01)                        e.cls = (iw[25] && iw[4]) ? 5 : 2;
        else if (iw[27:26] == 2'b00)                        e.cls = 0;
        else                                                e.cls = 5;
        if (e.cls == 0 && iw[25]) begin
            val = {24'd0, iw[7:0]};
            for (int k = 0; k < 2 * int'(iw[11:8]); k++) val = {val[0], val[31:1]};
            e.imm_valid = 1'b1;
            e.imm32     = val;
        end else if (e.cls == 2 && !iw[25]) begin
            e.imm_valid = 1'b1;
            e.imm32     = 32'(int'(iw[11:0]));
        end else if (e.cls == 3) begin
            off = int'(iw[23:0]);
            if (iw[23]) off = off - 32'h0100_0000;
            e.imm_valid = 1'b1;
            e.imm32     = 32'(off * 4);
        end
        return e;
    endfunction

    task automatic check_fields(input exp_t e);
        logic [31:0] iw;
        iw = e.iw;
        check_eq("class", 32'(bus.uop_class), 32'(e.cls));
        check_eq("imm_valid", 32'(bus.uop_imm_valid), 32'(e.imm_valid));
        if (e.imm_valid) check_eq("imm32", bus.uop_imm32, e.imm32);
        check_eq("link", 32'(bus.uop_link), 32'(e.cls == 3 && iw[24]));
        check_eq("acc", 32'(bus.uop_acc), 32'(e.cls == 1 && iw[21]));
        case (e.cls)
            0: begin
                check_eq("dp_opcode", 32'(bus.uop_opcode), 32'(iw[24:21]));
                check_eq("dp_s", 32'(bus.uop_s), 32'(iw[20]));
                check_eq("dp_rn", 32'(bus.uop_rn), 32'(iw[19:16]));
                check_eq("dp_rd", 32'(bus.uop_rd), 32'(iw[15:12]));
                if (!iw[25]) begin
                    check_eq("dp_rm", 32'(bus.uop_rm), 32'(iw[3:0]));
                    check_eq("dp_sh_type", 32'(bus.uop_shift_type), 32'(iw[6:5]));
                    check_eq("dp_sh_reg", 32'(bus.uop_shift_reg), 32'(iw[4]));
                    if (iw[4]) check_eq("dp_rs", 32'(bus.uop_rs), 32'(iw[11:8]));
                    else       check_eq("dp_sh_amt", 32'(bus.uop_shift_amt), 32'(iw[11:7]));
                end
            end
            1: begin
                check_eq("mul_s", 32'(bus.uop_s), 32'(iw[20]));
                check_eq("mul_rd", 32'(bus.uop_rd), 32'(iw[19:16]));
                check_eq("mul_rn", 32'(bus.uop_rn), 32'(iw[15:12]));
                check_eq("mul_rs", 32'(bus.uop_rs), 32'(iw[11:8]));
                check_eq("mul_rm", 32'(bus.uop_rm), 32'(iw[3:0]));
            end
            2: begin
                check_eq("mem_l", 32'(bus.uop_s), 32'(iw[20]));
                check_eq("mem_rn", 32'(bus.uop_rn), 32'(iw[19:16]));
                check_eq("mem_rd", 32'(bus.uop_rd), 32'(iw[15:12]));
                check_eq("mem_pubw", 32'(bus.uop_pubw), 32'(iw[24:21]));
                if (iw[25]) begin
                    check_eq("mem_rm", 32'(bus.uop_rm), 32'(iw[3:0]));
                    check_eq("mem_sh_type", 32'(bus.uop_shift_type), 32'(iw[6:5]));
                    check_eq("mem_sh_amt", 32'(bus.uop_shift_amt), 32'(iw[11:7]));
                end
            end
            default: begin
            end
        endcase
    endtask

    // One complete transaction. stall = cycles exec_ready held low after
    // exec_valid rises; done_dly = cycles from acceptance to exec_done
    // (0 = same cycle); hold_en keeps decode_en high throughout; abort
    // asserts rst while waiting for completion.
    task automatic run_txn(input logic [31:0] iw, input logic [3:0] fl, input int stall,
                           input int done_dly, input bit hold_en, input bit abort);
        exp_t e;
        int   start_acc;
        e         = model(iw, fl);
        start_acc = accepts;

        @(negedge clk);
        decode_en      = 1'b0;
        bus.exec_ready = 1'b0;
        bus.exec_done  = 1'b0;
        @(negedge clk);
        instr      = iw;
        cpsr_flags = fl;
        decode_en  = 1'b1;
        #1;
        check_eq("busy_on_edge", 32'(all_busy), 32'd1);

        @(negedge clk);                       // DECODE cycle
        if (!hold_en) decode_en = 1'b0;
        check_eq("valid_in_decode", 32'(bus.exec_valid), 32'd0);

        @(negedge clk);                       // E+2
        if (!e.pass) begin
            check_eq("busy_cond_fail", 32'(all_busy), 32'd0);
            check_eq("valid_cond_fail", 32'(bus.exec_valid), 32'd0);
            @(negedge clk);
            check_eq("no_issue_cond_fail", 32'(accepts), 32'(start_acc));
            decode_en = 1'b0;
            $display("txn instr=%08h flags=%h cond=fail", iw, fl);
            return;
        end
        check_eq("valid_e2", 32'(bus.exec_valid), 32'd1);
        check_fields(e);

        for (int s = 0; s < stall; s++) begin
            instr     = $urandom;
            decode_en = hold_en | (s % 2 == 0);
            @(negedge clk);
            check_eq("valid_stall", 32'(bus.exec_valid), 32'd1);
            check_fields(e);
        end

        decode_en      = hold_en;
        bus.exec_ready = 1'b1;
        bus.exec_done  = (done_dly == 0);
        @(negedge clk);
        bus.exec_ready = 1'b0;
        bus.exec_done  = 1'b0;
        check_eq("valid_after_accept", 32'(bus.exec_valid), 32'd0);
        check_eq("single_accept", 32'(accepts), 32'(start_acc + 1));

        if (done_dly == 0) begin
            check_eq("busy_done_same", 32'(all_busy), 32'd0);
        end else if (abort) begin
            check_eq("busy_wait", 32'(all_busy), 32'd1);
            #2 rst = 1'b1;
            #1;
            check_eq("busy_async_rst", 32'(all_busy), 32'd0);
            check_eq("valid_async_rst", 32'(bus.exec_valid), 32'd0);
            check_eq("imm32_async_rst", bus.uop_imm32, 32'd0);
            @(negedge clk);
            rst       = 1'b0;
            decode_en = 1'b0;
            $display("txn instr=%08h flags=%h aborted by reset", iw, fl);
            return;
        end else begin
            check_eq("busy_wait", 32'(all_busy), 32'd1);
            for (int d = 1; d < done_dly; d++) begin
                @(negedge clk);
                check_eq("busy_wait", 32'(all_busy), 32'd1);
            end
            bus.exec_done = 1'b1;
            @(negedge clk);
            bus.exec_done = 1'b0;
            check_eq("busy_after_done", 32'(all_busy), 32'd0);
        end

        if (hold_en) begin
            repeat (4) begin
                @(negedge clk);
                check_eq("no_retrigger_busy", 32'(all_busy), 32'd0);
            end
            check_eq("no_retrigger_issue", 32'(accepts), 32'(start_acc + 1));
            decode_en = 1'b0;
        end
        $display("txn instr=%08h flags=%h class=%0d stall=%0d done_dly=%0d hold=%0d",
                 iw, fl, e.cls, stall, done_dly, hold_en);
    endtask

    initial begin
        logic [31:0] iw;
        logic [3:0]  fl;
        int          kind;

        rst            = 1'b1;
        decode_en      = 1'b0;
        instr          = '0;
        cpsr_flags     = '0;
        bus.exec_ready = 1'b0;
        bus.exec_done  = 1'b0;
        #1;
        check_eq("reset_busy", 32'(all_busy), 32'd0);
        check_eq("reset_valid", 32'(bus.exec_valid), 32'd0);
        check_eq("reset_class", 32'(bus.uop_class), 32'd0);
        check_eq("reset_imm32", bus.uop_imm32, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run_txn(32'hE3A01005, 4'h0, 0, 3, 1'b0, 1'b0);   // MOV r1,#5
        run_txn(32'h03A01005, 4'h0, 0, 1, 1'b0, 1'b0);   // EQ, Z=0: dropped
        run_txn(32'h03A01005, 4'h4, 0, 1, 1'b0, 1'b0);   // EQ, Z=1: issued
        run_txn(32'hF3A01005, 4'hF, 0, 1, 1'b0, 1'b0);   // NV: dropped
        run_txn(32'hE3A004FF, 4'h0, 0, 0, 1'b0, 1'b0);   // rotated immediate
        run_txn(32'hEAFFFFFE, 4'h0, 0, 2, 1'b0, 1'b0);   // B .
        run_txn(32'hEB000010, 4'h0, 0, 1, 1'b0, 1'b0);   // BL +0x40
        run_txn(32'hE5932004, 4'h0, 0, 1, 1'b0, 1'b0);   // LDR r2,[r3,#4]
        run_txn(32'hE0221394, 4'h0, 0, 1, 1'b0, 1'b0);   // MLA
        run_txn(32'hEF000011, 4'h0, 0, 1, 1'b0, 1'b0);   // SWI
        run_txn(32'hE7F000F0, 4'h0, 0, 1, 1'b0, 1'b0);   // UND
        run_txn(32'hE3A01005, 4'h0, 5, 2, 1'b0, 1'b0);   // stalled handshake
        run_txn(32'hE0812003, 4'h0, 1, 3, 1'b0, 1'b1);   // reset during WAIT
        run_txn(32'hE3A01005, 4'h0, 0, 1, 1'b0, 1'b0);   // fresh decode after reset
        run_txn(32'hE3A02007, 4'h0, 0, 1, 1'b1, 1'b0);   // decode_en held across completion

        // Randomized cases
        for (int t = 0; t < 60; t++) begin
            iw   = $urandom;
            fl   = 4'($urandom);
            kind = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) iw[31:28] = 4'hE;
            case (kind)
                0: begin iw[27:22] = 6'd0; iw[7:4] = 4'b1001; end
                1: iw[27:25] = 3'b101;
                2: iw[27:24] = 4'hF;
                3: iw[27:26] = 2'b01;
                4: iw[27:26] = 2'b00;
                default: begin end
            endcase
            run_txn(iw, fl, $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 5) == 0), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
